// File: rtl/rtc_fmt_pkg.sv
// Shared types and constants for the RTC-to-UART timestamp formatter.
// RTC_FMT_WEEKDAY_EN selects the line length (21, or 24 with " Wd").
package rtc_fmt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT
    } state_t;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_TWO   = 8'h32;
    localparam logic [7:0] ASC_QMARK = 8'h3F;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_W     = 8'h57;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

`ifdef RTC_FMT_WEEKDAY_EN
    localparam int FRAME_LEN = 24;
`else
    localparam int FRAME_LEN = 21;
`endif

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

endpackage

// File: rtl/bcd_to_ascii.sv
// Purpose: one BCD nibble to its ASCII digit; non-decimal values become '?'.
// Latency: combinational.
// Backpressure: none.
module bcd_to_ascii
    import rtc_fmt_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASC_QMARK;
        if (nibble <= 4'd9) begin
            ascii = ASC_ZERO + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/rtc_uart_formatter.sv
// Purpose: DS1302 BCD snapshot -> "20YY-MM-DD HH:MM:SS\r\n" streamed to UART TX (RTC_FMT_WEEKDAY_EN adds " Wd").
// Latency: first txStart 3 cycles after rtcValid is sampled; each next char >= 2 cycles after txDone.
// Backpressure: holds each char while txBusy; rtcValid outside IDLE is dropped and counted.
module rtc_uart_formatter
    import rtc_fmt_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rtcValid,
    input  logic [7:0]        secData,
    input  logic [7:0]        minData,
    input  logic [7:0]        hrsData,
    input  logic [7:0]        dateData,
    input  logic [7:0]        monData,
    input  logic [7:0]        dayData,
    input  logic [7:0]        yrData,
    input  logic              txBusy,
    input  logic              txDone,
    output logic              txStart,
    output logic [CHAR_W-1:0] txData,
    output logic              busy,
    output logic              frameDone,
    output logic [DROP_W-1:0] dropCnt
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         sec_q, min_q, hrs_q, date_q, mon_q, yr_q;
    logic               snap_ld;
    logic               tx_start_d, frame_done_d;
    logic [CHAR_W-1:0]  tx_data_d;
    logic               accept;

    logic               is_const;
    logic [7:0]         const_chr;
    logic [3:0]         nib;
    logic [7:0]         nib_asc;
    logic [7:0]         chr;
    logic [3:0]         hrs_tens;

`ifdef RTC_FMT_WEEKDAY_EN
    logic [7:0]         day_q;
`endif

    // Bits the line never shows (CH, 12/24 spare, reserved fields).
    logic unused_bits;
`ifdef RTC_FMT_WEEKDAY_EN
    assign unused_bits = ^{sec_q[7], min_q[7], hrs_q[6], date_q[7:6], mon_q[7:5], day_q[7:3]};
`else
    assign unused_bits = ^{sec_q[7], min_q[7], hrs_q[6], date_q[7:6], mon_q[7:5], dayData};
`endif

    // 12 h mode keeps only bit 4 as the tens digit; bit 5 is AM/PM there.
    assign hrs_tens = hrs_q[7] ? {3'b000, hrs_q[4]} : {2'b00, hrs_q[5:4]};

    always_comb begin
        is_const  = 1'b1;
        const_chr = ASC_SPACE;
        nib       = 4'h0;
        case (int'(idx_q))
            0:  const_chr = ASC_TWO;
            1:  const_chr = ASC_ZERO;
            2:  begin is_const = 1'b0; nib = yr_q[7:4]; end
            3:  begin is_const = 1'b0; nib = yr_q[3:0]; end
            4:  const_chr = ASC_DASH;
            5:  begin is_const = 1'b0; nib = {3'b000, mon_q[4]}; end
            6:  begin is_const = 1'b0; nib = mon_q[3:0]; end
            7:  const_chr = ASC_DASH;
            8:  begin is_const = 1'b0; nib = {2'b00, date_q[5:4]}; end
            9:  begin is_const = 1'b0; nib = date_q[3:0]; end
            10: const_chr = ASC_SPACE;
            11: begin is_const = 1'b0; nib = hrs_tens; end
            12: begin is_const = 1'b0; nib = hrs_q[3:0]; end
            13: const_chr = ASC_COLON;
            14: begin is_const = 1'b0; nib = {1'b0, min_q[6:4]}; end
            15: begin is_const = 1'b0; nib = min_q[3:0]; end
            16: const_chr = ASC_COLON;
            17: begin is_const = 1'b0; nib = {1'b0, sec_q[6:4]}; end
            18: begin is_const = 1'b0; nib = sec_q[3:0]; end
`ifdef RTC_FMT_WEEKDAY_EN
            19: const_chr = ASC_SPACE;
            20: const_chr = ASC_W;
            21: begin is_const = 1'b0; nib = {1'b0, day_q[2:0]}; end
            22: const_chr = ASC_CR;
            23: const_chr = ASC_LF;
`else
            19: const_chr = ASC_CR;
            20: const_chr = ASC_LF;
`endif
            default: const_chr = ASC_SPACE;
        endcase
    end

    bcd_to_ascii u_bcd_to_ascii (
        .nibble (nib),
        .ascii  (nib_asc)
    );

    assign chr = is_const ? const_chr : nib_asc;

    // The frameDone cycle still belongs to the finished line, so a new snapshot is refused there.
    assign accept = (state_q == S_IDLE) && !frameDone;
    assign busy   = (state_q != S_IDLE) || frameDone;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tx_start_d   = 1'b0;
        tx_data_d    = txData;
        frame_done_d = 1'b0;
        snap_ld      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rtcValid && accept) begin
                    snap_ld = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!txBusy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = CHAR_W'(chr);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (txDone) begin
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            txStart   <= 1'b0;
            txData    <= '0;
            frameDone <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            txStart   <= tx_start_d;
            txData    <= tx_data_d;
            frameDone <= frame_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_q  <= '0;
            min_q  <= '0;
            hrs_q  <= '0;
            date_q <= '0;
            mon_q  <= '0;
            yr_q   <= '0;
`ifdef RTC_FMT_WEEKDAY_EN
            day_q  <= '0;
`endif
        end else if (snap_ld) begin
            sec_q  <= secData;
            min_q  <= minData;
            hrs_q  <= hrsData;
            date_q <= dateData;
            mon_q  <= monData;
            yr_q   <= yrData;
`ifdef RTC_FMT_WEEKDAY_EN
            day_q  <= dayData;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropCnt <= '0;
        end else if (rtcValid && !accept && (dropCnt != '1)) begin
            dropCnt <= dropCnt + 1'b1;
        end
    end

endmodule
